// File: rtl/escritor_banco_registros_pkg.sv
// Shared Beta definitions for the register-file write sequencer:
// sequencer states and the default data/address geometry.
package beta_pkg;

  localparam int BETA_DATA_W   = 32;
  localparam int BETA_ADDR_W   = 5;
  localparam int BETA_ZERO_REG = 31;

  // CLEAR only exists when the post-reset zero sweep is compiled in.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/escritor_banco_registros_if.sv
// Result channel from the execute/memory stages into the write sequencer.
// The producer drives valid/dest/data; the sequencer answers with ready.
interface escritor_banco_registros_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              In_Valid;
  logic              In_Ready;
  logic [ADDR_W-1:0] In_Dest;
  logic [DATA_W-1:0] In_Data;

  modport master (
    output In_Valid,
    output In_Dest,
    output In_Data,
    input  In_Ready
  );

  modport slave (
    input  In_Valid,
    input  In_Dest,
    input  In_Data,
    output In_Ready
  );

endinterface

// File: rtl/escritor_banco_registros_fifo.sv
// fifo_escritura: in-order buffer of pending register writes.
// Exposes every slot's destination and valid bit so the parent can
// look for read-after-write hazards without draining the queue.
module fifo_escritura #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_dest,
  input  logic [DATA_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              head_dest,
  output logic [DATA_W-1:0]              head_data,
  output logic [CNT_W-1:0]               count,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entry_dest,
  output logic [DEPTH-1:0]               entry_valid
);

  logic [DEPTH-1:0][ADDR_W-1:0] dest_r;
  logic [DEPTH-1:0][DATA_W-1:0] data_r;
  logic [DEPTH-1:0]             valid_r;
  logic [PTR_W-1:0]             wr_ptr_r;
  logic [PTR_W-1:0]             rd_ptr_r;
  logic [CNT_W-1:0]             count_r;
  logic                         do_push_s;
  logic                         do_pop_s;

  // Guard against overflow/underflow regardless of what the parent asks.
  always_comb begin
    do_push_s = push && (count_r < CNT_W'(DEPTH));
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Storage, valid bits and pointers; pointers wrap naturally (DEPTH is 2^n).
  // A push and a pop on the same edge always hit different slots because a
  // pop needs a non-empty queue and a push needs a non-full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_r   <= '0;
      data_r   <= '0;
      valid_r  <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (do_push_s) begin
        dest_r[wr_ptr_r]  <= push_dest;
        data_r[wr_ptr_r]  <= push_data;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_dest   = dest_r[rd_ptr_r];
  assign head_data   = data_r[rd_ptr_r];
  assign count       = count_r;
  assign entry_dest  = dest_r;
  assign entry_valid = valid_r;

endmodule

// File: rtl/escritor_banco_registros.sv
// escritor_banco_registros: owns the Beta register-file write port.
// Buffers results from the pipeline, retires one write per clock unless
// Hold borrows the port, and flags read-after-write hazards on Add_A/Add_B.
// Build option: define BANCO_CLEAR_EN to zero every register after reset.
module escritor_banco_registros
  import beta_pkg::*;
#(
  parameter int DATA_W   = BETA_DATA_W,
  parameter int ADDR_W   = BETA_ADDR_W,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = BETA_ZERO_REG,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  escritor_banco_registros_if.slave  in_ch,
  input  logic                       Hold,
  input  logic [ADDR_W-1:0]          Add_A,
  input  logic [ADDR_W-1:0]          Add_B,
  output logic                       Hazard_A,
  output logic                       Hazard_B,
  output logic [ADDR_W-1:0]          Add_Dest,
  output logic [DATA_W-1:0]          Write_Data,
  output logic                       Write_En,
  output logic [CNT_W-1:0]           Pend_Count,
  output logic                       Clear_Busy
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic                         run_s;
  logic                         live_s;
  logic                         in_ready_s;
  logic                         push_s;
  logic                         pop_s;
  logic [ADDR_W-1:0]            head_dest_s;
  logic [DATA_W-1:0]            head_data_s;
  logic [CNT_W-1:0]             count_s;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_dest_s;
  logic [DEPTH-1:0]             entry_valid_s;
  logic                         write_en_r;
  logic [ADDR_W-1:0]            add_dest_r;
  logic [DATA_W-1:0]            write_data_r;
  logic                         hazard_a_s;
  logic                         hazard_b_s;

`ifdef BANCO_CLEAR_EN
  state_t            state_r;
  logic [ADDR_W-1:0] clr_cnt_r;

  assign run_s      = (state_r == RUN);
  assign Clear_Busy = (state_r == CLEAR);
`else
  assign run_s      = 1'b1;
  assign Clear_Busy = 1'b0;
`endif

  // True when a pending write (queued or on the port right now) targets addr.
  function automatic logic pending_hit(
    input logic [ADDR_W-1:0]            addr,
    input logic [DEPTH-1:0][ADDR_W-1:0] dests,
    input logic [DEPTH-1:0]             vld,
    input logic                         we,
    input logic [ADDR_W-1:0]            wa
  );
    logic hit;
    hit = we && (wa == addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (dests[i] == addr)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Handshake and drain decisions; reset forces ready low combinationally.
  always_comb begin
    live_s     = run_s && !RST;
    in_ready_s = live_s && (count_s < CNT_W'(DEPTH));
    push_s     = in_ch.In_Valid && in_ready_s && (in_ch.In_Dest != ZERO_ADDR);
    pop_s      = live_s && !Hold && (count_s != {CNT_W{1'b0}});
  end

  assign in_ch.In_Ready = in_ready_s;

  fifo_escritura #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RST),
    .push        (push_s),
    .pop         (pop_s),
    .push_dest   (in_ch.In_Dest),
    .push_data   (in_ch.In_Data),
    .head_dest   (head_dest_s),
    .head_data   (head_data_s),
    .count       (count_s),
    .entry_dest  (entry_dest_s),
    .entry_valid (entry_valid_s)
  );

  // Register-file port: zero sweep after reset (if built in), then drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      write_en_r   <= 1'b0;
      add_dest_r   <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
`ifdef BANCO_CLEAR_EN
      state_r      <= CLEAR;
      clr_cnt_r    <= {ADDR_W{1'b0}};
`endif
    end else begin
`ifdef BANCO_CLEAR_EN
      if (state_r == CLEAR) begin
        write_en_r   <= 1'b1;
        add_dest_r   <= clr_cnt_r;
        write_data_r <= {DATA_W{1'b0}};
        clr_cnt_r    <= clr_cnt_r + ADDR_W'(1);
        if (clr_cnt_r == {ADDR_W{1'b1}}) begin
          state_r <= RUN;
        end else begin
          state_r <= CLEAR;
        end
      end else
`endif
      if (pop_s) begin
        write_en_r   <= 1'b1;
        add_dest_r   <= head_dest_s;
        write_data_r <= head_data_s;
      end else begin
        write_en_r   <= 1'b0;
      end
    end
  end

  // Read-after-write hazards; the zero register never conflicts.
  always_comb begin
    if (live_s) begin
      hazard_a_s = (Add_A != ZERO_ADDR) &&
                   pending_hit(Add_A, entry_dest_s, entry_valid_s, write_en_r, add_dest_r);
      hazard_b_s = (Add_B != ZERO_ADDR) &&
                   pending_hit(Add_B, entry_dest_s, entry_valid_s, write_en_r, add_dest_r);
    end else begin
      hazard_a_s = 1'b0;
      hazard_b_s = 1'b0;
    end
  end

  assign Hazard_A   = hazard_a_s;
  assign Hazard_B   = hazard_b_s;
  assign Write_En   = write_en_r;
  assign Add_Dest   = add_dest_r;
  assign Write_Data = write_data_r;
  assign Pend_Count = count_s;

endmodule

// File: tb/tb_escritor_banco_registros.sv
// Directed bench for escritor_banco_registros (default geometry: 32-bit
// data, 32 registers, 4-entry queue, register 31 hard-wired to zero).
module tb_escritor_banco_registros;

  logic        CLK;
  logic        RST;
  logic        Hold;
  logic [4:0]  Add_A;
  logic [4:0]  Add_B;
  logic        Hazard_A;
  logic        Hazard_B;
  logic [4:0]  Add_Dest;
  logic [31:0] Write_Data;
  logic        Write_En;
  logic [2:0]  Pend_Count;
  logic        Clear_Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  escritor_banco_registros_if #(.ADDR_W(5), .DATA_W(32)) in_if ();

  escritor_banco_registros #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .DEPTH    (4),
    .ZERO_REG (31)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_ch      (in_if),
    .Hold       (Hold),
    .Add_A      (Add_A),
    .Add_B      (Add_B),
    .Hazard_A   (Hazard_A),
    .Hazard_B   (Hazard_B),
    .Add_Dest   (Add_Dest),
    .Write_Data (Write_Data),
    .Write_En   (Write_En),
    .Pend_Count (Pend_Count),
    .Clear_Busy (Clear_Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST            = 1'b1;
    Hold           = 1'b0;
    Add_A          = 5'd0;
    Add_B          = 5'd0;
    in_if.In_Valid = 1'b0;
    in_if.In_Dest  = 5'd0;
    in_if.In_Data  = 32'h0;

    // Reset state
    #2;
    check("rst_we",    64'(Write_En),   64'd0);
    check("rst_dest",  64'(Add_Dest),   64'd0);
    check("rst_data",  64'(Write_Data), 64'd0);
    check("rst_pend",  64'(Pend_Count), 64'd0);
    check("rst_ready", 64'(in_if.In_Ready), 64'd0);
    check("rst_haza",  64'(Hazard_A),   64'd0);
    check("rst_hazb",  64'(Hazard_B),   64'd0);

    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;

`ifdef BANCO_CLEAR_EN
    // Zero sweep over all 32 registers
    check("clr_busy", 64'(Clear_Busy), 64'd1);
    check("clr_ready", 64'(in_if.In_Ready), 64'd0);
    for (int i = 0; i < 32; i++) begin
      step();
      check("clr_we",   64'(Write_En),   64'd1);
      check("clr_dest", 64'(Add_Dest),   64'(i));
      check("clr_data", 64'(Write_Data), 64'd0);
    end
`endif
    check("run_busy",  64'(Clear_Busy), 64'd0);
    check("run_ready", 64'(in_if.In_Ready), 64'd1);
    step();
    check("idle_we",   64'(Write_En), 64'd0);

    // Two back-to-back results: (3,0x15) then (7,0x23)
    in_if.In_Valid = 1'b1;
    in_if.In_Dest  = 5'd3;
    in_if.In_Data  = 32'h15;
    step();
    in_if.In_Dest  = 5'd7;
    in_if.In_Data  = 32'h23;
    check("b2b_pend1", 64'(Pend_Count), 64'd1);
    check("b2b_we0",   64'(Write_En),   64'd0);
    step();
    in_if.In_Valid = 1'b0;
    check("b2b_we1",   64'(Write_En),   64'd1);
    check("b2b_dest1", 64'(Add_Dest),   64'd3);
    check("b2b_data1", 64'(Write_Data), 64'h15);
    check("b2b_pend2", 64'(Pend_Count), 64'd1);
    step();
    check("b2b_we2",   64'(Write_En),   64'd1);
    check("b2b_dest2", 64'(Add_Dest),   64'd7);
    check("b2b_data2", 64'(Write_Data), 64'h23);
    check("b2b_pend3", 64'(Pend_Count), 64'd0);
    step();
    check("b2b_we3",   64'(Write_En),   64'd0);

    // Hold with five offered results: only four fit
    Hold           = 1'b1;
    in_if.In_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_if.In_Dest = 5'(10 + i);
      in_if.In_Data = 32'h100 + 32'(i);
      #1;
      check("full_ready", 64'(in_if.In_Ready), (i < 4) ? 64'd1 : 64'd0);
      step();
      check("full_pend", 64'(Pend_Count), (i < 4) ? 64'(i + 1) : 64'd4);
      check("full_we",   64'(Write_En),   64'd0);
    end
    in_if.In_Valid = 1'b0;
    check("full_ready_end", 64'(in_if.In_Ready), 64'd0);
    Hold = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check("drain_we",   64'(Write_En),   64'd1);
      check("drain_dest", 64'(Add_Dest),   64'(10 + j));
      check("drain_data", 64'(Write_Data), 64'h100 + 64'(j));
      check("drain_pend", 64'(Pend_Count), 64'(3 - j));
      check("drain_ready", 64'(in_if.In_Ready), 64'd1);
    end
    step();
    check("drain_we_end", 64'(Write_En), 64'd0);

    // Write to the zero register is swallowed
    in_if.In_Valid = 1'b1;
    in_if.In_Dest  = 5'd31;
    in_if.In_Data  = 32'hDEAD;
    Add_A          = 5'd31;
    #1;
    check("zero_ready", 64'(in_if.In_Ready), 64'd1);
    check("zero_haza0", 64'(Hazard_A),       64'd0);
    step();
    in_if.In_Valid = 1'b0;
    check("zero_pend",  64'(Pend_Count), 64'd0);
    check("zero_we0",   64'(Write_En),   64'd0);
    check("zero_haza1", 64'(Hazard_A),   64'd0);
    step();
    check("zero_we1",   64'(Write_En),   64'd0);

    // Hazard on A follows the write from queue to port, then clears
    Hold           = 1'b1;
    in_if.In_Valid = 1'b1;
    in_if.In_Dest  = 5'd9;
    in_if.In_Data  = 32'h1;
    Add_A          = 5'd9;
    Add_B          = 5'd4;
    #1;
    check("haz_a_pre", 64'(Hazard_A), 64'd0);
    step();
    in_if.In_Valid = 1'b0;
    check("haz_pend",  64'(Pend_Count), 64'd1);
    check("haz_a_q",   64'(Hazard_A),   64'd1);
    check("haz_b_q",   64'(Hazard_B),   64'd0);
    step();
    check("haz_we_hold", 64'(Write_En), 64'd0);
    check("haz_a_hold",  64'(Hazard_A), 64'd1);
    Hold = 1'b0;
    step();
    check("haz_we",    64'(Write_En),   64'd1);
    check("haz_dest",  64'(Add_Dest),   64'd9);
    check("haz_data",  64'(Write_Data), 64'h1);
    check("haz_a_wp",  64'(Hazard_A),   64'd1);
    check("haz_b_wp",  64'(Hazard_B),   64'd0);
    check("haz_pend0", 64'(Pend_Count), 64'd0);
    step();
    check("haz_we_end", 64'(Write_En), 64'd0);
    check("haz_a_end",  64'(Hazard_A), 64'd0);

    // Reset mid-drain discards everything pending
    Hold           = 1'b1;
    in_if.In_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_if.In_Dest = (i == 0) ? 5'd5 : ((i == 1) ? 5'd6 : 5'd8);
      in_if.In_Data = 32'h50 + 32'(i);
      step();
    end
    in_if.In_Valid = 1'b0;
    Add_A          = 5'd6;
    #1;
    check("mr_pend3", 64'(Pend_Count), 64'd3);
    check("mr_haza",  64'(Hazard_A),   64'd1);
    Hold = 1'b0;
    step();
    check("mr_we1",   64'(Write_En),   64'd1);
    check("mr_dest",  64'(Add_Dest),   64'd5);
    check("mr_pend2", 64'(Pend_Count), 64'd2);
    #2;
    RST = 1'b1;
    #1;
    check("mr_we0",    64'(Write_En),   64'd0);
    check("mr_pend0",  64'(Pend_Count), 64'd0);
    check("mr_ready",  64'(in_if.In_Ready), 64'd0);
    check("mr_haza0",  64'(Hazard_A),   64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
`ifdef BANCO_CLEAR_EN
    repeat (33) step();
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_post_we",   64'(Write_En),   64'd0);
      check("mr_post_pend", 64'(Pend_Count), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
